prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Parametrised, writable successor to the fixed 16x8 instruction ROM.
- Holds the CPU program and serves instruction fetches with a registered 1-cycle read.
- Can be reprogrammed at run time through a byte-stream loader port with valid/ready handshake.
- While a load is in progress, `cpu_hold` is raised to stall the core; a completion pulse is issued when the load ends.

Parameters:
- DATA_W, 8: instruction word width in bits.
- DEPTH, 16: number of words; any value from 2 to 4096, power of two not required.
- ADDR_W, $clog2(DEPTH): address width; derived, not to be overridden.
- OOR_WORD, all ones (halt/jump-to-self encoding): word returned for fetch addresses >= DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  fetch request, sampled on clk.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_data  out  DATA_W  registered read data.
- fetch_valid  out  1  one-cycle pulse; fetch_data is valid while high.
- ld_start  in  1  one-cycle pulse that begins a load.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  qualifies ld_data as the final word.
- ld_ready  out  1  loader accepts a word this cycle.
- ld_done  out  1  one-cycle pulse at load completion.
- ld_count  out  ADDR_W+1  number of words written by the most recent load.
- cpu_hold  out  1  stall request to the core.

Behaviour:
- Memory array is not reset. Initial contents are all zero. Array contents survive rst_n.
- Reset values of outputs:
  - fetch_data = 0, fetch_valid = 0, ld_ready = 0, ld_done = 0, ld_count = 0, cpu_hold = 0.
  - State = RUN; write pointer wptr = 0.
- FSM states: RUN, LOAD, DONE.
- RUN:
  - ld_ready = 0, cpu_hold = 0.
  - fetch_en=1 at edge N: fetch_data = mem[fetch_addr] (or OOR_WORD if fetch_addr >= DEPTH) and fetch_valid = 1 after edge N; fetch_valid = 0 after edge N+1 unless fetch_en is still 1. Back-to-back fetches run at one per cycle.
  - fetch_en=0: fetch_data holds its last value.
  - ld_start=1: next state LOAD, wptr <= 0, ld_count <= 0. A fetch requested in the same cycle still completes, using pre-load contents.
- LOAD:
  - ld_ready = 1, cpu_hold = 1.
  - fetch_en is ignored; fetch_valid = 0.
  - ld_start is ignored.
  - Transfer occurs when ld_valid & ld_ready: mem[wptr] <= ld_data, wptr <= wptr+1, ld_count <= ld_count+1.
  - Go to DONE when a transfer has ld_last=1, or when the transfer writes address DEPTH-1 (full). Extra words are never written; no wrap-around.
  - ld_valid with ld_ready=0 (any state other than LOAD) is dropped silently.
  - Words not written by a short load keep their previous contents.
- DONE:
  - Lasts exactly one cycle: ld_done = 1, cpu_hold = 1, ld_ready = 0. Then RUN.
  - ld_count holds its final value until the next ld_start.
- Read/write collision: a write and a read to the same address in the same cycle cannot occur, because fetches are blocked during LOAD.
- Reset mid-load (rst_n low in any state):
  - Outputs return to reset values asynchronously; state = RUN.
  - Words already written remain; the remaining words keep their old contents.
  - No ld_done is issued for the aborted load.
- Width rules:
  - wptr and ld_count are ADDR_W+1 bits, so a full load gives ld_count = DEPTH without overflow.
  - fetch_addr compare against DEPTH is unsigned.

Test Plan:
1. Reset, then ld_start and 16 words 0x00..0x0F with ld_last on the 4th word (0x03) -> exactly 4 transfers accepted, ld_done pulses 1 cycle after the 4th, ld_count = 4, cpu_hold high from the cycle after ld_start through DONE; fetch of addresses 0..3 returns 0x00..0x03; fetch of addr 4 returns 0x00 (untouched).
2. Full load of DEPTH=16 words 0xB7,0x01,...,0xFF with no ld_last -> ld_done after the 16th transfer, ld_count = 16, ld_ready low afterwards; back-to-back fetches 0..15 return the loaded image with fetch_valid high on 16 consecutive cycles, 1-cycle latency.
3. DEPTH=12, fetch_addr = 13 -> fetch_data = OOR_WORD (0xFF), fetch_valid = 1.
4. ld_start and fetch_en in the same cycle, addr 2 holding 0xE1 -> fetch_data = 0xE1 with fetch_valid = 1; a fetch_en issued during LOAD produces no fetch_valid.
5. Assert rst_n low after 3 of 8 words -> all outputs at reset values, state RUN, no ld_done; fetch of addresses 0..2 returns the new words, address 3 returns the old word.
6. ld_valid toggling with gaps during LOAD, ld_valid pulses while in RUN -> only words presented during LOAD are written, in order; RUN-state pulses are ignored and leave memory unchanged.

Source files
------------

// File: rtl/prog_mem_loader.sv
// Writable instruction memory with registered 1-cycle fetch port and a
// valid/ready byte-stream loader that stalls the core while reprogramming.
module prog_mem_loader #(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 16,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] OOR_WORD = '1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_en,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_fetch_valid,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  output logic              o_ld_done,
  output logic [ADDR_W:0]   o_ld_count,
  output logic              o_cpu_hold
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_P  = (ADDR_W+1)'(DEPTH);

  // Array has no reset so a program survives rst_n; it powers up cleared.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_ld_count;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_fetch_valid;
  logic              r_ld_ready;
  logic              r_ld_done;
  logic              r_cpu_hold;
  logic              w_xfer;
  logic              w_fetch;
  logic              w_oor;
  logic              w_full;
  logic [DATA_W-1:0] w_rd_word;

  assign w_xfer  = r_ld_ready & i_ld_valid;
  assign w_fetch = (r_state == ST_RUN) & i_fetch_en;
  assign w_oor   = ({1'b0, i_fetch_addr} >= DEPTH_P);
  assign w_full  = (r_wptr == LAST_PTR);

  // Next-state decode and fetch read mux.
  always_comb begin
    w_next_state = r_state;
    w_rd_word    = OOR_WORD;
    case (r_state)
      ST_RUN: begin
        if (i_ld_start) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (w_xfer && (i_ld_last || w_full)) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_DONE: w_next_state = ST_RUN;
      default: w_next_state = ST_RUN;
    endcase
    if (w_oor) begin
      w_rd_word = OOR_WORD;
    end else begin
      w_rd_word = r_mem[i_fetch_addr];
    end
  end

  // State register; handshake/stall outputs registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_ld_ready <= 1'b0;
      r_ld_done  <= 1'b0;
      r_cpu_hold <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ld_ready <= (w_next_state == ST_LOAD);
      r_ld_done  <= (w_next_state == ST_DONE);
      r_cpu_hold <= (w_next_state != ST_RUN);
    end
  end

  // Fetch pipeline stage; fetch_data holds when no fetch is served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
    end else if (w_fetch) begin
      r_fetch_data  <= w_rd_word;
      r_fetch_valid <= 1'b1;
    end else begin
      r_fetch_valid <= 1'b0;
    end
  end

  // Write pointer and word counter for the current load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_ld_count <= '0;
    end else if ((r_state == ST_RUN) && i_ld_start) begin
      r_wptr     <= '0;
      r_ld_count <= '0;
    end else if (w_xfer) begin
      r_wptr     <= r_wptr + {{ADDR_W{1'b0}}, 1'b1};
      r_ld_count <= r_ld_count + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  // Array write port; leaving LOAD on a full pointer prevents wrap-around.
  always_ff @(posedge i_clk) begin
    if (w_xfer) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= i_ld_data;
    end
  end

  assign o_fetch_data  = r_fetch_data;
  assign o_fetch_valid = r_fetch_valid;
  assign o_ld_ready    = r_ld_ready;
  assign o_ld_done     = r_ld_done;
  assign o_ld_count    = r_ld_count;
  assign o_cpu_hold    = r_cpu_hold;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: fetch results are checked through an
// expected-value queue, loader/stall behaviour through direct assertions.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_en;
  logic [3:0] fetch_addr;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  wire  [7:0] fetch_data;
  wire        fetch_valid;
  wire        ld_ready;
  wire        ld_done;
  wire  [4:0] ld_count;
  wire        cpu_hold;

  logic       fetch_en_b;
  logic [3:0] fetch_addr_b;
  wire  [7:0] fetch_data_b;
  wire        fetch_valid_b;
  wire        ld_ready_b;
  wire        ld_done_b;
  wire  [4:0] ld_count_b;
  wire        cpu_hold_b;

  int         tests = 0;
  int         fails = 0;
  int         done_total = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] img[20];

  always #5 clk = ~clk;

  prog_mem_loader #(.DATA_W(8), .DEPTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_en(fetch_en), .i_fetch_addr(fetch_addr),
    .o_fetch_data(fetch_data), .o_fetch_valid(fetch_valid),
    .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_data(ld_data),
    .i_ld_last(ld_last), .o_ld_ready(ld_ready), .o_ld_done(ld_done),
    .o_ld_count(ld_count), .o_cpu_hold(cpu_hold)
  );

  prog_mem_loader #(.DATA_W(8), .DEPTH(12)) dut12 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_en(fetch_en_b), .i_fetch_addr(fetch_addr_b),
    .o_fetch_data(fetch_data_b), .o_fetch_valid(fetch_valid_b),
    .i_ld_start(1'b0), .i_ld_valid(1'b0), .i_ld_data(8'h00),
    .i_ld_last(1'b0), .o_ld_ready(ld_ready_b), .o_ld_done(ld_done_b),
    .o_ld_count(ld_count_b), .o_cpu_hold(cpu_hold_b)
  );

  // Fetch scoreboard and ld_done pulse counter, sampled mid-cycle.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (ld_done) done_total++;
    if (fetch_valid) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_fetch_valid obs=%0h exp=none", fetch_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        assert (fetch_data === e) else begin
          fails++;
          $error("FAIL fetch_data obs=%0h exp=%0h", fetch_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [3:0] a, input logic [7:0] e);
    fetch_en   = 1'b1;
    fetch_addr = a;
    exp_q.push_back(e);
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fetch_data"}, 32'(fetch_data), 32'h0);
    chk({tag, "_fetch_valid"}, 32'(fetch_valid), 32'h0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'h0);
    chk({tag, "_ld_done"}, 32'(ld_done), 32'h0);
    chk({tag, "_ld_count"}, 32'(ld_count), 32'h0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'h0);
  endtask

  // Presents img[0..n-1] one per cycle; counts accepted words, measures the
  // cycles from the last accept to ld_done and counts ld_done pulses.
  task automatic load(input bit do_start, input int n, input int last_idx,
                      output int acc, output int gap, output int dones);
    int acc_cyc;
    int d0;
    acc = 0; gap = -1; acc_cyc = 0; d0 = done_total;
    if (do_start) begin
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("start_hold", 32'(cpu_hold), 32'h1);
      chk("start_ready", 32'(ld_ready), 32'h1);
    end
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = (i == last_idx);
      if (ld_ready) begin
        acc++;
        acc_cyc = cyc;
      end
      tick();
      if (ld_done && gap < 0) begin
        gap = cyc - acc_cyc;
        chk("done_hold", 32'(cpu_hold), 32'h1);
        chk("done_ready", 32'(ld_ready), 32'h0);
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    tick();
    dones = done_total - d0;
  endtask

  initial begin
    int acc, gap, dones, d0, k;
    logic [5:0] pat;
    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = 4'd0; ld_start = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    fetch_en_b = 1'b0; fetch_addr_b = 4'd0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: short load terminated by ld_last on the 4th word
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    load(1'b1, 16, 3, acc, gap, dones);
    chk("t1_accepted", 32'(acc), 32'd4);
    chk("t1_done_gap", 32'(gap), 32'd1);
    chk("t1_done_pulses", 32'(dones), 32'd1);
    chk("t1_ld_count", 32'(ld_count), 32'd4);
    chk("t1_hold_after", 32'(cpu_hold), 32'h0);
    for (int i = 0; i < 4; i++) fetch(4'(i), 8'(i));
    fetch(4'd4, 8'h00);

    // 2: full load with extra words presented; back-to-back image read
    img[0] = 8'hB7;
    for (int i = 1; i < 15; i++) img[i] = 8'(i);
    img[15] = 8'hFF; img[16] = 8'hAA; img[17] = 8'hAA;
    load(1'b1, 18, -1, acc, gap, dones);
    chk("t2_accepted", 32'(acc), 32'd16);
    chk("t2_done_gap", 32'(gap), 32'd1);
    chk("t2_done_pulses", 32'(dones), 32'd1);
    chk("t2_ld_count", 32'(ld_count), 32'd16);
    chk("t2_ready_after", 32'(ld_ready), 32'h0);
    for (int i = 0; i < 16; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = 4'(i);
      exp_q.push_back(img[i]);
      tick();
      chk("t2_b2b_valid", 32'(fetch_valid), 32'h1);
    end
    fetch_en = 1'b0;
    tick();
    chk("t2_b2b_end", 32'(fetch_valid), 32'h0);

    // 3: DEPTH=12 out-of-range fetch
    fetch_en_b = 1'b1; fetch_addr_b = 4'd13;
    tick();
    chk("t3_oor_data", 32'(fetch_data_b), 32'hFF);
    chk("t3_oor_valid", 32'(fetch_valid_b), 32'h1);
    fetch_addr_b = 4'd11;
    tick();
    chk("t3_last_word", 32'(fetch_data_b), 32'h00);
    fetch_en_b = 1'b0;
    tick();
    chk("t3_valid_drop", 32'(fetch_valid_b), 32'h0);

    // 4: fetch coinciding with ld_start, fetch ignored during LOAD
    img[0] = 8'h10; img[1] = 8'h11; img[2] = 8'hE1;
    load(1'b1, 3, 2, acc, gap, dones);
    chk("t4_setup_acc", 32'(acc), 32'd3);
    ld_start = 1'b1; fetch_en = 1'b1; fetch_addr = 4'd2;
    exp_q.push_back(8'hE1);
    tick();
    ld_start = 1'b0; fetch_addr = 4'd5;
    chk("t4_same_cycle_valid", 32'(fetch_valid), 32'h1);
    chk("t4_hold", 32'(cpu_hold), 32'h1);
    tick();
    chk("t4_load_fetch_valid", 32'(fetch_valid), 32'h0);
    tick();
    fetch_en = 1'b0;
    img[0] = 8'h55;
    load(1'b0, 1, 0, acc, gap, dones);
    chk("t4_accepted", 32'(acc), 32'd1);
    chk("t4_done_pulses", 32'(dones), 32'd1);
    chk("t4_ld_count", 32'(ld_count), 32'd1);
    fetch(4'd0, 8'h55);
    fetch(4'd2, 8'hE1);

    // 5: reset after 3 of 8 words
    for (int i = 0; i < 8; i++) img[i] = 8'hC0 + 8'(i);
    d0 = done_total;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = img[i];
      tick();
    end
    ld_data = img[3];
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    ld_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_no_done", 32'(done_total - d0), 32'd0);
    chk("t5_ready", 32'(ld_ready), 32'h0);
    chk("t5_hold", 32'(cpu_hold), 32'h0);
    for (int i = 0; i < 3; i++) fetch(4'(i), img[i]);
    fetch(4'd3, 8'h03);

    // 6: gapped ld_valid during LOAD, stray ld_valid in RUN
    ld_valid = 1'b1; ld_data = 8'h99;
    tick();
    tick();
    ld_valid = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    k = 0;
    pat = 6'b101001;
    for (int c = 0; c < 6; c++) begin
      ld_valid = pat[c];
      ld_data  = pat[c] ? 8'h60 + 8'(k) : 8'h77;
      ld_last  = pat[c] && (k == 2);
      if (ld_valid && ld_ready) k++;
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    ld_valid = 1'b1; ld_data = 8'h99;
    tick();
    tick();
    ld_valid = 1'b0;
    tick();
    chk("t6_accepted", 32'(k), 32'd3);
    chk("t6_ld_count", 32'(ld_count), 32'd3);
    for (int i = 0; i < 3; i++) fetch(4'(i), 8'h60 + 8'(i));
    fetch(4'd3, 8'h03);
    fetch(4'd4, 8'h04);
    fetch(4'd5, 8'h05);

    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
